// File: rtl/echo_pkg.sv
// Shared types and constants for the echo_unit audio post-processing stage.
package echo_pkg;

    localparam int unsigned SAMPLE_W = 16;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        MIX   = 2'd2,
        WRITE = 2'd3
    } echo_state_t;

    // Clamp a 17-bit signed sum to the 16-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] w);
        if (w[SAMPLE_W] != w[SAMPLE_W-1])
            return w[SAMPLE_W] ? SAT_MIN : SAT_MAX;
        else
            return w[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/echo_unit_if.sv
// Sample stream handshake between the synth core and the echo stage.
interface echo_unit_if;
    import echo_pkg::*;

    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       sample_out_valid;

    modport master (
        output sample_in, sample_valid,
        input  sample_out, sample_out_valid
    );

    modport slave (
        input  sample_in, sample_valid,
        output sample_out, sample_out_valid
    );
endinterface

// File: rtl/echo_delay_ram.sv
// Single-port synchronous delay-line RAM, write-first, 1-cycle read latency, no reset.
module echo_delay_ram #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
            dout      <= din;
        end else begin
            dout      <= mem[addr];
        end
    end

endmodule

// File: rtl/echo_unit.sv
// Feedback echo: mixes a decayed copy of the sample from 2^ADDR_W samples ago into each new sample.
// Define ECHO_SATURATE_EN to clamp the mix instead of wrapping it.
module echo_unit
    import echo_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DECAY_SHIFT = 1
) (
    input  logic        clk,
    input  logic        reset,
    echo_unit_if.slave  bus,
    input  logic        echo_on,
    input  logic        clear,
    output logic        primed,
    output logic        overrun
);

    echo_state_t state, state_nxt;

    logic [ADDR_W-1:0]          ptr;
    logic                       clear_pend;
    logic signed [SAMPLE_W-1:0] dry_q, dly_q;
    logic signed [SAMPLE_W-1:0] eff, eff_sh, mix_res;
    logic [SAMPLE_W-1:0]        ram_din, ram_dout;
    logic                       load_dry, load_dly, load_out, ram_we;

    echo_delay_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ptr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.sample_valid) state_nxt = READ;
            READ:    state_nxt = MIX;
            MIX:     state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_dry = 1'b0;
        load_dly = 1'b0;
        load_out = 1'b0;
        ram_we   = 1'b0;
        case (state)
            IDLE:    load_dry = bus.sample_valid;
            READ:    load_dly = 1'b1;
            MIX:     load_out = 1'b1;
            WRITE:   ram_we   = 1'b1;
            default: ;
        endcase
    end

    // Unwritten history is masked by primed, so RAM needs no initialisation.
    always_comb begin
        eff     = (primed && echo_on) ? dly_q : '0;
        eff_sh  = eff >>> DECAY_SHIFT;
        ram_din = echo_on ? bus.sample_out : dry_q;
    end

`ifdef ECHO_SATURATE_EN
    logic signed [SAMPLE_W:0] wet;
    always_comb begin
        wet     = (SAMPLE_W+1)'(dry_q) + (SAMPLE_W+1)'(eff_sh);
        mix_res = sat16(wet);
    end
`else
    // 16-bit sum equals the low bits of the 17-bit wet value.
    always_comb mix_res = dry_q + eff_sh;
`endif

    always_ff @(posedge clk) begin
        if (load_dry) dry_q <= bus.sample_in;
        if (load_dly) dly_q <= ram_dout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.sample_out       <= '0;
            bus.sample_out_valid <= 1'b0;
            primed               <= 1'b0;
            overrun              <= 1'b0;
            ptr                  <= '0;
            clear_pend           <= 1'b0;
        end else begin
            bus.sample_out_valid <= load_out;
            if (load_out) bus.sample_out <= mix_res;

            if (bus.sample_valid && state != IDLE) overrun <= 1'b1;
            else if (clear)                        overrun <= 1'b0;

            // A clear seen mid-sample is held until the sample's write completes.
            case (state)
                IDLE: begin
                    if (clear) begin
                        ptr    <= '0;
                        primed <= 1'b0;
                    end
                end
                READ, MIX: begin
                    if (clear) clear_pend <= 1'b1;
                end
                WRITE: begin
                    if (clear || clear_pend) begin
                        ptr        <= '0;
                        primed     <= 1'b0;
                        clear_pend <= 1'b0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                        if (ptr == '1) primed <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
